// File: rtl/nr_residual_checker_pkg.sv
// Shared types and constants for the Newton-Raphson residual checker:
// FP constants, FSM states and the micro-op record driving the shared FP units.
package nr_fp_pkg;

   localparam logic [31:0] FP_ONE      = 32'h3F800000;
   localparam logic [31:0] FP_TWO      = 32'h40000000;
   localparam logic [31:0] FP_THREE    = 32'h40400000;
   localparam logic [31:0] TOL_DEFAULT = 32'h3A83126F;
   localparam int          NSTEPS_C    = 22;
   localparam int          NSCR        = 22;

   // Scratch slots 19..21 hold the final residuals F1..F3.
   localparam logic [4:0] IDX_F1 = 5'd19;
   localparam logic [4:0] IDX_F2 = 5'd20;
   localparam logic [4:0] IDX_F3 = 5'd21;

   typedef enum logic [1:0] {IDLE, EVAL, CHECK, HOLD} state_e;

   typedef enum logic [1:0] {OP_MUL, OP_ADD, OP_SUB} uop_e;

   typedef enum logic [4:0] {
      S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_T8, S_T9,
      S_T10, S_T11, S_T12, S_T13, S_T14, S_T15, S_T16, S_T17, S_T18,
      S_X1, S_X2, S_X3, S_ONE, S_TWO, S_THREE
   } src_e;

   typedef struct packed {
      uop_e       op;
      src_e       src_a;
      src_e       src_b;
      logic [4:0] dst;
   } uop_t;

   // Magnitude compare on raw bits; NaN/Inf fail regardless of the limit.
   function automatic logic res_ok(input logic [31:0] f, input logic [31:0] tol);
      return (f[30:23] != 8'hFF) && (f[30:0] <= tol[30:0]);
   endfunction

endpackage

// File: rtl/nr_residual_checker_rom.sv
// Fixed 22-step micro-op schedule evaluating f1, f2, f3 on one MUL and one ADD/SUB.
module nr_residual_rom
   import nr_fp_pkg::*;
(
   input  logic [4:0] step_i,
   output uop_t       uop_o
);
   always_comb begin
      uop_o = '{OP_MUL, S_X1, S_X1, 5'd0};
      case (step_i)
         5'd0:  uop_o = '{OP_MUL, S_X1,    S_X1,  5'd0};
         5'd1:  uop_o = '{OP_ADD, S_X1,    S_X1,  5'd1};
         5'd2:  uop_o = '{OP_MUL, S_X2,    S_X2,  5'd2};
         5'd3:  uop_o = '{OP_SUB, S_T0,    S_T1,  5'd3};
         5'd4:  uop_o = '{OP_ADD, S_T3,    S_T2,  5'd4};
         5'd5:  uop_o = '{OP_SUB, S_T4,    S_X3,  5'd5};
         5'd6:  uop_o = '{OP_ADD, S_T5,    S_ONE, IDX_F1};
         5'd7:  uop_o = '{OP_MUL, S_X1,    S_T2,  5'd6};
         5'd8:  uop_o = '{OP_MUL, S_THREE, S_X2,  5'd7};
         5'd9:  uop_o = '{OP_MUL, S_X2,    S_X3,  5'd8};
         5'd10: uop_o = '{OP_SUB, S_T6,    S_X1,  5'd9};
         5'd11: uop_o = '{OP_SUB, S_T9,    S_T7,  5'd10};
         5'd12: uop_o = '{OP_ADD, S_T10,   S_T8,  5'd11};
         5'd13: uop_o = '{OP_ADD, S_T11,   S_TWO, IDX_F2};
         5'd14: uop_o = '{OP_MUL, S_X3,    S_X3,  5'd12};
         5'd15: uop_o = '{OP_MUL, S_X1,    S_T12, 5'd13};
         5'd16: uop_o = '{OP_MUL, S_THREE, S_X3,  5'd14};
         5'd17: uop_o = '{OP_MUL, S_T12,   S_X2,  5'd15};
         5'd18: uop_o = '{OP_MUL, S_X1,    S_X2,  5'd16};
         5'd19: uop_o = '{OP_SUB, S_T13,   S_T14, 5'd17};
         5'd20: uop_o = '{OP_ADD, S_T17,   S_T15, 5'd18};
         5'd21: uop_o = '{OP_ADD, S_T18,   S_T16, IDX_F3};
         default: uop_o = '{OP_MUL, S_X1, S_X1, 5'd0};
      endcase
   end
endmodule

// File: rtl/nr_residual_fp.sv
// Shared single-precision FP units: round-to-nearest-even, subnormals flushed
// to zero, canonical quiet NaN 32'h7FC00000 on invalid or NaN operands.
module Multiplication (
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic [31:0] y_o
);
   logic              sgn, g, s, up, nan;
   logic [7:0]        ea, eb;
   logic [47:0]       p;
   logic [23:0]       m;
   logic [24:0]       rnd;
   logic signed [9:0] ex;

   always_comb begin
      sgn = a_i[31] ^ b_i[31];
      ea  = a_i[30:23];
      eb  = b_i[30:23];
      nan = (ea == 8'hFF && a_i[22:0] != 23'd0) || (eb == 8'hFF && b_i[22:0] != 23'd0) ||
            (ea == 8'hFF && eb == 8'd0) || (eb == 8'hFF && ea == 8'd0);
      p   = {1'b1, a_i[22:0]} * {1'b1, b_i[22:0]};
      ex  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
      if (p[47]) begin
         m  = p[47:24];
         g  = p[23];
         s  = |p[22:0];
         ex = ex + 10'sd1;
      end else begin
         m  = p[46:23];
         g  = p[22];
         s  = |p[21:0];
      end
      up  = g & (s | m[0]);
      rnd = {1'b0, m} + {24'd0, up};
      if (rnd[24]) begin
         rnd = rnd >> 1;
         ex  = ex + 10'sd1;
      end
      if (nan)                              y_o = 32'h7FC00000;
      else if (ea == 8'hFF || eb == 8'hFF)  y_o = {sgn, 8'hFF, 23'd0};
      else if (ea == 8'd0 || eb == 8'd0)    y_o = {sgn, 31'd0};
      else if (ex >= 10'sd255)              y_o = {sgn, 8'hFF, 23'd0};
      else if (ex <= 10'sd0)                y_o = {sgn, 31'd0};
      else                                  y_o = {sgn, ex[7:0], rnd[22:0]};
   end
endmodule

module Addition_Subtraction (
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  logic        sub_i,
   output logic [31:0] y_o
);
   logic              sa, sb, sl, ss, swap, stk, found, up;
   logic [7:0]        ea, eb, el, es, d;
   logic [26:0]       ma, mb, ml, ms, msh, mask, nrm;
   logic [27:0]       sum;
   logic [4:0]        lz;
   logic [24:0]       rnd;
   logic signed [9:0] ex;

   always_comb begin
      sa   = a_i[31];
      sb   = b_i[31] ^ sub_i;
      ea   = a_i[30:23];
      eb   = b_i[30:23];
      ma   = (ea == 8'd0) ? 27'd0 : {1'b1, a_i[22:0], 3'b000};
      mb   = (eb == 8'd0) ? 27'd0 : {1'b1, b_i[22:0], 3'b000};
      swap = {eb, mb} > {ea, ma};
      sl   = swap ? sb : sa;
      ss   = swap ? sa : sb;
      el   = swap ? eb : ea;
      es   = swap ? ea : eb;
      ml   = swap ? mb : ma;
      ms   = swap ? ma : mb;
      d    = el - es;
      mask = 27'd0;
      if (d >= 8'd27) begin
         msh = 27'd0;
         stk = |ms;
      end else begin
         mask = (27'd1 << d) - 27'd1;
         msh  = ms >> d;
         stk  = |(ms & mask);
      end
      // Bits shifted out collapse into a sticky LSB below the guard/round pair.
      msh[0] = msh[0] | stk;
      sum    = (sl == ss) ? ({1'b0, ml} + {1'b0, msh}) : ({1'b0, ml} - {1'b0, msh});
      ex     = $signed({2'b00, el});
      lz     = 5'd0;
      found  = 1'b0;
      if (sum[27]) begin
         nrm    = sum[27:1];
         nrm[0] = sum[1] | sum[0];
         ex     = ex + 10'sd1;
      end else begin
         for (int i = 26; i >= 0; i--) begin
            if (!found && sum[i]) begin
               lz    = 5'(26 - i);
               found = 1'b1;
            end
         end
         nrm = sum[26:0] << lz;
         ex  = ex - $signed({5'd0, lz});
      end
      up  = nrm[2] & ((|nrm[1:0]) | nrm[3]);
      rnd = {1'b0, nrm[26:3]} + {24'd0, up};
      if (rnd[24]) begin
         rnd = rnd >> 1;
         ex  = ex + 10'sd1;
      end
      if ((ea == 8'hFF && a_i[22:0] != 23'd0) || (eb == 8'hFF && b_i[22:0] != 23'd0) ||
          (ea == 8'hFF && eb == 8'hFF && sa != sb))
         y_o = 32'h7FC00000;
      else if (ea == 8'hFF)       y_o = {sa, 8'hFF, 23'd0};
      else if (eb == 8'hFF)       y_o = {sb, 8'hFF, 23'd0};
      else if (sum == 28'd0)      y_o = {sl & ss, 31'd0};
      else if (ex >= 10'sd255)    y_o = {sl, 8'hFF, 23'd0};
      else if (ex <= 10'sd0)      y_o = {sl, 31'd0};
      else                        y_o = {sl, ex[7:0], rnd[22:0]};
   end
endmodule

// File: rtl/nr_residual_checker.sv
// Re-evaluates the Newton-Raphson system at a candidate root and flags
// whether every residual is within TOL, sharing one FP multiplier and adder.
//
// state | meaning
// IDLE  | waiting for a candidate vector (in_ready high)
// EVAL  | one micro-op per cycle, steps 0..NSTEPS-1
// CHECK | register residuals and pass flag
// HOLD  | result presented until out_ready
module nr_residual_checker
   import nr_fp_pkg::*;
#(
   parameter logic [31:0] TOL    = TOL_DEFAULT,
   parameter int          NSTEPS = NSTEPS_C
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] x1,
   input  logic [31:0] x2,
   input  logic [31:0] x3,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] f1,
   output logic [31:0] f2,
   output logic [31:0] f3,
   output logic        pass
);
   localparam logic [4:0] LAST_STEP = 5'(NSTEPS - 1);

   state_e      state_q;
   logic [4:0]  step_q;
   logic [31:0] x1_q, x2_q, x3_q;
   logic [31:0] scr_q [NSCR];
   logic [31:0] f1_q, f2_q, f3_q;
   logic        pass_q, out_valid_q, in_ready_q;

   uop_t        uop;
   logic [31:0] opa, opb, mul_y, add_y, res;

   nr_residual_rom u_rom (
      .step_i (step_q),
      .uop_o  (uop)
   );

   function automatic logic [31:0] pick(input src_e s, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] c,
                                        input logic [31:0] t);
      case (s)
         S_X1:    return a;
         S_X2:    return b;
         S_X3:    return c;
         S_ONE:   return FP_ONE;
         S_TWO:   return FP_TWO;
         S_THREE: return FP_THREE;
         default: return t;
      endcase
   endfunction

   always_comb begin
      opa = pick(uop.src_a, x1_q, x2_q, x3_q, scr_q[5'(uop.src_a)]);
      opb = pick(uop.src_b, x1_q, x2_q, x3_q, scr_q[5'(uop.src_b)]);
   end

   Multiplication u_mul (
      .a_i (opa),
      .b_i (opb),
      .y_o (mul_y)
   );

   Addition_Subtraction u_add (
      .a_i   (opa),
      .b_i   (opb),
      .sub_i (uop.op == OP_SUB),
      .y_o   (add_y)
   );

   assign res = (uop.op == OP_MUL) ? mul_y : add_y;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         step_q      <= 5'd0;
         x1_q        <= 32'd0;
         x2_q        <= 32'd0;
         x3_q        <= 32'd0;
         for (int i = 0; i < NSCR; i++) scr_q[i] <= 32'd0;
         f1_q        <= 32'd0;
         f2_q        <= 32'd0;
         f3_q        <= 32'd0;
         pass_q      <= 1'b0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               in_ready_q <= 1'b1;
               if (in_valid && in_ready_q) begin
                  x1_q       <= x1;
                  x2_q       <= x2;
                  x3_q       <= x3;
                  step_q     <= 5'd0;
                  in_ready_q <= 1'b0;
                  state_q    <= EVAL;
               end
            end
            EVAL: begin
               scr_q[uop.dst] <= res;
               if (step_q == LAST_STEP) begin
                  step_q  <= 5'd0;
                  state_q <= CHECK;
               end else begin
                  step_q <= step_q + 5'd1;
               end
            end
            CHECK: begin
               f1_q        <= scr_q[IDX_F1];
               f2_q        <= scr_q[IDX_F2];
               f3_q        <= scr_q[IDX_F3];
               pass_q      <= res_ok(scr_q[IDX_F1], TOL) && res_ok(scr_q[IDX_F2], TOL) &&
                              res_ok(scr_q[IDX_F3], TOL);
               out_valid_q <= 1'b1;
               state_q     <= HOLD;
            end
            HOLD: begin
               // Input acceptance waits for IDLE so a result is never overwritten.
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign f1        = f1_q;
   assign f2        = f2_q;
   assign f3        = f3_q;
   assign pass      = pass_q;

endmodule

// File: tb/tb_nr_residual_checker.sv
// Scoreboard bench: integer-valued candidates are modelled exactly in integer
// arithmetic, converted to single precision, and compared when results appear.
module tb_nr_residual_checker;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, out_ready;
   logic [31:0] x1, x2, x3;
   logic        in_ready, out_valid, pass;
   logic [31:0] f1, f2, f3;
   logic        rdy_t2, ov_t2, pass_t2, rdy_t3, ov_t3, pass_t3;
   logic [31:0] f1_t2, f2_t2, f3_t2, f1_t3, f2_t3, f3_t3;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int acc_cnt = 0;

   typedef struct {
      logic [31:0] f1, f2, f3;
      logic        p0, p2, p3;
      logic        nan;
      int          acc;
   } exp_t;

   exp_t sb_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (in_valid && in_ready) acc_cnt <= acc_cnt + 1;

   nr_residual_checker u_dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .x1(x1), .x2(x2), .x3(x3), .out_valid(out_valid), .out_ready(out_ready),
      .f1(f1), .f2(f2), .f3(f3), .pass(pass));

   nr_residual_checker #(.TOL(32'h40000000)) u_tol2 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_t2),
      .x1(x1), .x2(x2), .x3(x3), .out_valid(ov_t2), .out_ready(out_ready),
      .f1(f1_t2), .f2(f2_t2), .f3(f3_t2), .pass(pass_t2));

   nr_residual_checker #(.TOL(32'h3FFFFFFF)) u_tol3 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_t3),
      .x1(x1), .x2(x2), .x3(x3), .out_valid(ov_t3), .out_ready(out_ready),
      .f1(f1_t3), .f2(f2_t3), .f3(f3_t3), .pass(pass_t3));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] i2f(input int v);
      int          a;
      int          p;
      logic [31:0] r;
      if (v == 0) return 32'd0;
      a = (v < 0) ? -v : v;
      p = 0;
      for (int i = 0; i < 31; i++) if (a[i]) p = i;
      r[31]    = (v < 0);
      r[30:23] = 8'(127 + p);
      r[22:0]  = 23'(a << (23 - p));
      return r;
   endfunction

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   function automatic exp_t model(input int a, input int b, input int c);
      exp_t e;
      int   r1, r2, r3;
      r1    = a*a - 2*a + b*b - c + 1;
      r2    = a*b*b - a - 3*b + b*c + 2;
      r3    = a*c*c - 3*c + b*c*c + a*b;
      e.f1  = i2f(r1);
      e.f2  = i2f(r2);
      e.f3  = i2f(r3);
      e.p0  = (r1 == 0) && (r2 == 0) && (r3 == 0);
      e.p2  = (iabs(r1) <= 2) && (iabs(r2) <= 2) && (iabs(r3) <= 2);
      e.p3  = (iabs(r1) <= 1) && (iabs(r2) <= 1) && (iabs(r3) <= 1);
      e.nan = 1'b0;
      e.acc = 0;
      return e;
   endfunction

   // Zero residuals may carry either sign.
   function automatic logic [31:0] zmask(input logic [31:0] e);
      return (e[30:0] == 31'd0) ? 32'h7FFFFFFF : 32'hFFFFFFFF;
   endfunction

   task automatic check_result(input exp_t e);
      if (e.nan) begin
         chk("f1_exp_ff", {24'd0, f1[30:23]}, 32'hFF);
         chk("f2_exp_ff", {24'd0, f2[30:23]}, 32'hFF);
         chk("f3_exp_ff", {24'd0, f3[30:23]}, 32'hFF);
      end else begin
         chk("f1", f1 & zmask(e.f1), e.f1 & zmask(e.f1));
         chk("f2", f2 & zmask(e.f2), e.f2 & zmask(e.f2));
         chk("f3", f3 & zmask(e.f3), e.f3 & zmask(e.f3));
      end
      chk("pass", {31'd0, pass}, {31'd0, e.p0});
      chk("pass_tol2", {31'd0, pass_t2}, {31'd0, e.p2});
      chk("pass_tol3", {31'd0, pass_t3}, {31'd0, e.p3});
      chk("out_valid", {31'd0, out_valid}, 32'd1);
      chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
   endtask

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                       input exp_t e, input bit keep);
      int k;
      in_valid = 1'b1;
      x1 = a; x2 = b; x3 = c;
      k = 0;
      do begin @(negedge clk); k++; end while (!in_ready && k < 60);
      if (!in_ready) begin
         chk("in_ready_timeout", 32'd0, 32'd1);
         in_valid = 1'b0;
         return;
      end
      e.acc = cyc + 1;
      sb_q.push_back(e);
      @(posedge clk); #1;
      if (!keep) begin
         in_valid = 1'b0;
         x1 = $urandom; x2 = $urandom; x3 = $urandom;
      end
   endtask

   // Returns at the falling edge after the output handshake.
   task automatic recv(input int hold);
      int   k;
      exp_t e;
      k = 0;
      do begin @(negedge clk); k++; end while (!out_valid && k < 60);
      if (!out_valid) begin
         chk("out_valid_timeout", 32'd0, 32'd1);
         return;
      end
      if (sb_q.size() == 0) begin
         chk("scoreboard_empty", 32'd0, 32'd1);
         return;
      end
      e = sb_q.pop_front();
      chk("latency", cyc, e.acc + 23);
      check_result(e);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         check_result(e);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      @(negedge clk);
      chk("out_valid_cleared", {31'd0, out_valid}, 32'd0);
      chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
   endtask

   task automatic run_int(input int a, input int b, input int c);
      @(posedge clk); #1;
      send(i2f(a), i2f(b), i2f(c), model(a, b, c), 1'b0);
      recv(0);
   endtask

   initial begin
      exp_t e;
      int   a0, ra, rb, rc;
      reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      x1 = 32'd0; x2 = 32'd0; x3 = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_f1", f1, 32'd0);
      chk("rst_pass", {31'd0, pass}, 32'd0);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk); reset = 1'b1;

      run_int(1, 2, 3);
      run_int(1, 1, 1);
      run_int(0, 0, 0);

      e = '{f1: 32'd0, f2: 32'd0, f3: 32'd0, p0: 1'b0, p2: 1'b0, p3: 1'b0, nan: 1'b1, acc: 0};
      @(posedge clk); #1;
      send(32'h7FC00000, i2f(1), i2f(1), e, 1'b0);
      recv(0);

      for (int i = 0; i < 6; i++) begin
         ra = int'($urandom_range(8, 0)) - 4;
         rb = int'($urandom_range(8, 0)) - 4;
         rc = int'($urandom_range(8, 0)) - 4;
         run_int(ra, rb, rc);
      end

      // Back-pressure with in_valid held high: one acceptance after the handshake.
      a0 = acc_cnt;
      @(posedge clk); #1;
      send(i2f(1), i2f(2), i2f(3), model(1, 2, 3), 1'b1);
      recv(10);
      e = model(1, 2, 3);
      e.acc = cyc + 1;
      sb_q.push_back(e);
      @(posedge clk); #1;
      in_valid = 1'b0;
      x1 = $urandom; x2 = $urandom; x3 = $urandom;
      recv(0);
      chk("accept_count", acc_cnt, a0 + 2);

      // Abort at EVAL step 10.
      @(posedge clk); #1;
      send(i2f(2), i2f(3), i2f(4), model(2, 3, 4), 1'b0);
      repeat (10) @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      chk("abort_f1", f1, 32'd0);
      chk("abort_f3", f3, 32'd0);
      chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
      chk("abort_in_ready", {31'd0, in_ready}, 32'd0);
      void'(sb_q.pop_back());
      @(negedge clk); @(negedge clk);
      reset = 1'b1;
      run_int(1, 2, 3);
      chk("scoreboard_drained", sb_q.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/nr_residual_checker.md
Name: nr_residual_checker

Overview:
- Consumer of the Newton-Raphson solver's root vector. It takes a candidate (x1,x2,x3) in IEEE-754 single precision and re-evaluates the three system equations:
  - f1 = x1² − 2x1 + x2² − x3 + 1
  - f2 = x1·x2² − x1 − 3x2 + x2·x3 + 2
  - f3 = x1·x3² − 3x3 + x2·x3² + x1·x2
- It reports the residuals and a pass flag (all |fi| ≤ TOL).
- Area-lean: one shared Multiplication and one shared Addition_Subtraction instance are sequenced by a 22-step micro-op schedule.

Parameters:
- TOL, 32'h3A83126F, residual magnitude limit (0.001 as an IEEE-754 single).
- NSTEPS, 22, number of micro-ops in the schedule (fixed; exposed for the bench only).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  candidate vector present.
- in_ready  out  1  block can accept a vector.
- x1, x2, x3  in  32 each  candidate root, IEEE-754 single.
- out_valid  out  1  residuals and pass are valid.
- out_ready  in  1  downstream accepts the result.
- f1, f2, f3  out  32 each  residuals, IEEE-754 single.
- pass  out  1  1 = every residual magnitude ≤ TOL and none is NaN or Inf.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE; step counter and scratch registers are 0.
  - f1, f2, f3 = 0; pass = 0; out_valid = 0.
  - in_ready = 0 while reset is low.
- FSM states:
  - IDLE: in_ready = 1. When in_valid=1 at a clock edge, latch x1–x3 and go to EVAL with step = 0.
  - EVAL: one micro-op per cycle. Each op is either MUL or ADD/SUB. Sources are drawn from {x1, x2, x3, scratch t0..t18, constants 1.0/2.0/3.0}; the result is written to one scratch entry. When step = 21 completes, go to CHECK.
  - CHECK: one cycle. Register f1–f3 and pass, set out_valid = 1, go to HOLD.
  - HOLD: f1–f3 and pass stay stable. When out_ready=1 at an edge, clear out_valid and go to IDLE.
- Latency:
  - Vector accepted at edge N → out_valid = 1 after edge N+23.
  - Throughput is one vector per at least 24 cycles.
- Schedule (fixed order):
  - f1 ops: t0 = x1·x1, t1 = x1+x1, t2 = x2·x2, t3 = t0−t1, t4 = t3+t2, t5 = t4−x3, F1 = t5+1.0.
  - f2 ops: t6 = x1·t2, t7 = 3.0·x2, t8 = x2·x3, t9 = t6−x1, t10 = t9−t7, t11 = t10+t8, F2 = t11+2.0.
  - f3 ops: t12 = x3·x3, t13 = x1·t12, t14 = 3.0·x3, t15 = t12·x2, t16 = x1·x2, t17 = t13−t14, t18 = t17+t15, F3 = t18+t16.
- Arithmetic: bit-exact to the shared FP units; no extra rounding or normalisation is added.
- Pass test, per residual:
  - Take magnitude = bits[30:0] and compare it as an unsigned integer against TOL[30:0] (≤ passes).
  - Exponent == 8'hFF (NaN or Inf) forces fail.
  - +0 and −0 both pass.
- Boundaries:
  - in_ready = 0 in EVAL, CHECK and HOLD; in_valid there is ignored and nothing is queued.
  - out_ready is ignored outside HOLD.
  - In HOLD, in_valid and out_ready together: only the output handshake completes; the input is accepted at the earliest on the next cycle, in IDLE.
  - Reset mid-EVAL or mid-HOLD: immediate abort to reset values; the partial result is never presented.
  - Input latches do not change after acceptance even if x1–x3 change.

Decomposition:
- Package nr_fp_pkg contains:
  - FP constants FP_ONE = 32'h3F800000, FP_TWO = 32'h40000000, FP_THREE = 32'h40400000, default TOL;
  - state enum {IDLE, EVAL, CHECK, HOLD};
  - micro-op type {MUL, ADD, SUB};
  - operand-select enum;
  - micro-op record {op, srcA, srcB, dst}.
- Sub-module nr_residual_rom: combinational step → micro-op table (22 entries).
- The top module instantiates one Multiplication and one Addition_Subtraction and muxes their operands from the ROM fields.

Test Plan:
- x = (1.0, 2.0, 3.0) → after 23 cycles: f1 = 32'h3F800000, f2 = 32'h40A00000, f3 = 32'h41A00000, pass = 0.
- x = (1.0, 1.0, 1.0), the exact root → f1[30:0] = f2[30:0] = f3[30:0] = 0, pass = 1.
- TOL = 32'h40000000, x = (0, 0, 0) → f1 = 1.0, f2 = 2.0, f3 = 0, pass = 1 (boundary ≤). Same input with TOL = 32'h3FFFFFFF → pass = 0.
- x1 = 32'h7FC00000 (NaN), x2 = x3 = 1.0 → pass = 0, out_valid still asserted at N+23.
- out_ready held low for 10 cycles, in_valid held high throughout → outputs stable, in_ready = 0, exactly one acceptance after the output handshake.
- reset pulsed low at step 10 of EVAL → all outputs 0 immediately. The next vector (1,2,3) gives the first-scenario result with no residue from the aborted run.
